// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with increment, branch, and call/return through a LIFO return stack.
module pc_sequencer #(
  parameter int PC_WIDTH = 5,
  parameter int STACK_DEPTH = 4,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  localparam int DW = $clog2(STACK_DEPTH + 1),
  localparam int AW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                control,
  input  logic [PC_WIDTH-1:0] target,
  input  logic                doBranch,
  input  logic                doCall,
  input  logic                doReturn,
  output logic [PC_WIDTH-1:0] pc,
  output logic [DW-1:0]       depth,
  output logic                stack_empty,
  output logic                stack_full,
  output logic                overflow_err,
  output logic                underflow_err
);
  logic [PC_WIDTH-1:0] stack [STACK_DEPTH];
  logic [PC_WIDTH-1:0] pc_inc, pc_nxt;
  logic [DW-1:0] depth_dec, depth_nxt;
  logic push, pop, ovf, unf;
  assign pc_inc = pc + 1'b1;
  assign depth_dec = depth - 1'b1;
  assign stack_empty = depth == '0;
  assign stack_full = depth == DW'(STACK_DEPTH);
  always_comb begin
    pop  = control & doReturn & ~stack_empty;
    unf  = control & doReturn & stack_empty;
    push = control & ~doReturn & doCall & ~stack_full;
    ovf  = control & ~doReturn & doCall & stack_full;
    pc_nxt = !control ? pc :
             pop ? stack[depth_dec[AW-1:0]] :
             push ? target :
             (doReturn | doCall) ? pc_inc :
             doBranch ? target : pc_inc;
    depth_nxt = pop ? depth_dec : push ? depth + 1'b1 : depth;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc <= RESET_VECTOR;
      depth <= '0;
      overflow_err <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      pc <= pc_nxt;
      depth <= depth_nxt;
      overflow_err <= overflow_err | ovf;
      underflow_err <= underflow_err | unf;
    end
  // Return addresses need no reset: only entries below depth are ever read.
  always_ff @(posedge clk)
    if (push) stack[depth[AW-1:0]] <= pc_inc;
endmodule
